// File: rtl/accum_pkg.sv
// Shared types for the byte accumulator: FSM state encoding and datapath width.
package accum_pkg;

    localparam int DATA_W = 8;

    // IDLE: no beat yet, ACCUM: frame in progress, DONE: result held for the consumer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple adder with carry-in; overflow is the unsigned carry-out.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow
);

    logic [8:0] full;

    // Nine-bit add so the carry-out falls into the top bit
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
    end

    assign sum      = full[7:0];
    assign overflow = full[8];

endmodule

// File: rtl/byte_accumulator.sv
// Byte accumulator: sums a frame of bytes modulo 256, tracks carry-out as a
// sticky overflow flag, counts beats with saturation, and holds the result
// until the consumer takes it.
module byte_accumulator
    import accum_pkg::*;
#(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_sum,
    output logic                 out_overflow,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state;
    state_t                next_state;
    logic [DATA_W-1:0]     acc;
    logic                  ovf;
    logic [CNT_WIDTH-1:0]  count;
    logic [DATA_W-1:0]     add_sum;
    logic                  add_ovf;
    logic                  beat;
    logic                  release_result;

    // Clear wins over both a beat and a result hand-off
    assign beat           = in_valid && (state != DONE) && !clear;
    assign release_result = (state == DONE) && out_ready && !clear;

    assign in_ready     = (state != DONE);
    assign out_valid    = (state == DONE);
    assign out_sum      = acc;
    assign out_overflow = ovf;
    assign out_count    = count;

    adder_8bit u_adder (
        .a        (acc),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; a last beat goes straight to DONE even from IDLE
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (beat) next_state = in_last ? DONE : ACCUM;
                ACCUM:   if (beat && in_last) next_state = DONE;
                DONE:    if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath: accumulate on beats, zero on abort or once the result is taken
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (clear || release_result) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (beat) begin
            acc   <= add_sum;
            ovf   <= ovf | add_ovf;
            count <= (count == CNT_MAX) ? count : count + 1'b1;
        end
    end

endmodule

// File: tb/tb_byte_accumulator.sv
// Self-checking bench for byte_accumulator: directed frames plus randomized
// frames compared against a frame-level arithmetic model.
module tb_byte_accumulator;

    localparam int CNT_WIDTH = 4;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clk;
    logic                 n_rst;
    logic                 clear;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_sum;
    logic                 out_overflow;
    logic [CNT_WIDTH-1:0] out_count;

    int checks;
    int errors;

    // Frame model: true (unbounded) total of bytes, number of bytes, result held
    int unsigned m_total;
    int          m_beats;
    bit          m_done;

    byte_accumulator #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_total = 0;
        m_beats = 0;
        m_done  = 1'b0;
    endtask

    // Expected outputs follow from the frame contents: a carry happened at
    // some step exactly when the true total reached 256.
    task automatic check_model(input string tag);
        int exp_cnt;
        exp_cnt = (m_beats > CNT_MAX) ? CNT_MAX : m_beats;
        chk({tag, ".out_valid"}, {31'd0, out_valid},    {31'd0, m_done});
        chk({tag, ".in_ready"},  {31'd0, in_ready},     {31'd0, !m_done});
        chk({tag, ".out_sum"},   {24'd0, out_sum},      m_total & 32'hFF);
        chk({tag, ".out_ovf"},   {31'd0, out_overflow}, {31'd0, (m_total >= 256)});
        chk({tag, ".out_count"}, {28'd0, out_count},    exp_cnt);
    endtask

    // One offered beat; optionally with a coinciding clear
    task automatic send(input string tag, input logic [7:0] d, input bit last, input bit clr);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        clear    = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b0;
        if (clr) model_reset();
        else begin
            m_total += d;
            m_beats++;
            if (last) m_done = 1'b1;
        end
        check_model(tag);
    endtask

    // An idle or stalled cycle; junk beats offered while done must be ignored
    task automatic wait_cycle(input string tag, input bit junk);
        in_valid = junk;
        in_data  = 8'($urandom);
        in_last  = junk & 1'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_model(tag);
    endtask

    // Hand off the result while a beat is offered: nothing may be accepted
    task automatic take_result(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_last   = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        model_reset();
        check_model(tag);
    endtask

    initial begin
        int len;
        checks    = 0;
        errors    = 0;
        n_rst     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Reset values
        #12;
        check_model("reset");
        n_rst = 1'b1;
        @(posedge clk); #1;
        check_model("post_reset");

        // 0x10+0x20+0x30
        send("f1_b0", 8'h10, 1'b0, 1'b0);
        send("f1_b1", 8'h20, 1'b0, 1'b0);
        send("f1_last", 8'h30, 1'b1, 1'b0);
        chk("f1_sum_abs", {24'd0, out_sum}, 32'h60);
        chk("f1_cnt_abs", {28'd0, out_count}, 32'd3);
        take_result("f1_idle");

        // Carry sets the sticky flag
        send("f2_b0", 8'hF0, 1'b0, 1'b0);
        send("f2_last", 8'h20, 1'b1, 1'b0);
        chk("f2_sum_abs", {24'd0, out_sum}, 32'h10);
        chk("f2_ovf_abs", {31'd0, out_overflow}, 32'd1);
        take_result("f2_idle");

        // Single-byte frame held under back-pressure, junk ignored
        send("f3_last", 8'h05, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) wait_cycle("f3_hold", 1'b1);
        chk("f3_sum_abs", {24'd0, out_sum}, 32'h05);
        take_result("f3_idle");

        // Count saturates at 15, sum keeps going
        for (int i = 0; i < 17; i++) send("f4_beat", 8'h01, (i == 16), 1'b0);
        chk("f4_cnt_abs", {28'd0, out_count}, 32'd15);
        chk("f4_sum_abs", {24'd0, out_sum}, 32'h11);
        take_result("f4_idle");

        // Clear beats a coinciding last beat
        send("f5_b0", 8'h40, 1'b0, 1'b0);
        send("f5_b1", 8'h40, 1'b0, 1'b0);
        send("f5_clr", 8'h40, 1'b1, 1'b1);
        chk("f5_sum_abs", {24'd0, out_sum}, 32'h00);
        send("f5_next", 8'h07, 1'b1, 1'b0);
        chk("f5_next_cnt", {28'd0, out_count}, 32'd1);

        // Clear in DONE together with out_ready
        out_ready = 1'b1;
        clear     = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        clear     = 1'b0;
        model_reset();
        check_model("done_clr");

        // Asynchronous reset mid-frame
        send("f6_b0", 8'h80, 1'b0, 1'b0);
        send("f6_b1", 8'h90, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        #2;
        n_rst = 1'b1;
        send("f6_next", 8'h01, 1'b1, 1'b0);
        chk("f6_sum_abs", {24'd0, out_sum}, 32'h01);
        take_result("f6_idle");

        // Randomized frames with gaps, stalls and occasional aborts
        for (int f = 0; f < 25; f++) begin
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) wait_cycle("rnd_gap", 1'b0);
                if ($urandom_range(0, 15) == 0) begin
                    send("rnd_clr", 8'($urandom), 1'($urandom), 1'b1);
                end else begin
                    send("rnd_beat", 8'($urandom), (i == len - 1), 1'b0);
                end
            end
            if (m_done) begin
                len = int'($urandom_range(0, 3));
                for (int i = 0; i < len; i++) wait_cycle("rnd_hold", 1'b1);
                take_result("rnd_idle");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
